// File: rtl/shot_alarm_if.sv
// shot_alarm_if: groups the shot-clock inputs and the alarm/display outputs of shot_alarm
interface shot_alarm_if;
    logic [3:0] count;
    logic       buzz;
    logic       clear;
    logic       buzzer;
    logic [6:0] seg;
    logic       warn;
    logic       alarm_active;
    logic [7:0] viol_cnt;

    modport master (output count, buzz, clear,
                    input  buzzer, seg, warn, alarm_active, viol_cnt);
    modport slave  (input  count, buzz, clear,
                    output buzzer, seg, warn, alarm_active, viol_cnt);
endinterface

// File: rtl/shot_alarm.sv
// shot_alarm: shot-clock warning beeps, violation alarm, count display and violation counter
module shot_alarm #(
    parameter int ALARM_CYC   = 8,
    parameter int BEEP_HALF   = 2,
    parameter int WARN_THRESH = 3
) (
    input logic        clk,
    input logic        rst,
    shot_alarm_if.slave bus
);
    localparam int LW = ALARM_CYC > 1 ? $clog2(ALARM_CYC) : 1;
    localparam int TW = BEEP_HALF > 1 ? $clog2(BEEP_HALF) : 1;

    typedef enum logic [1:0] {IDLE, WARN, ALARM, HOLD} state_t;

    state_t        state;
    logic          buzz_q;
    logic [3:0]    count_q;
    logic [LW-1:0] len;
    logic [TW-1:0] tone;
    logic          hit;
    logic          in_range;

    assign hit      = bus.buzz & ~buzz_q;
    assign in_range = bus.count >= 4'd1 && bus.count <= 4'(WARN_THRESH);

    function automatic logic [6:0] digit(input logic [3:0] v);
        case (v)
            4'd0:    digit = 7'h3F;
            4'd1:    digit = 7'h06;
            4'd2:    digit = 7'h5B;
            4'd3:    digit = 7'h4F;
            4'd4:    digit = 7'h66;
            4'd5:    digit = 7'h6D;
            4'd6:    digit = 7'h7D;
            4'd7:    digit = 7'h07;
            4'd8:    digit = 7'h7F;
            4'd9:    digit = 7'h6F;
            default: digit = 7'h40;
        endcase
    endfunction

    // Alarm FSM: a buzz edge always wins and (re)starts ALARM; tone doubles as the WARN beep timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            bus.buzzer       <= 1'b0;
            bus.alarm_active <= 1'b0;
            len              <= '0;
            tone             <= '0;
        end else if (hit) begin
            state            <= ALARM;
            bus.buzzer       <= 1'b1;
            bus.alarm_active <= 1'b1;
            len              <= '0;
            tone             <= '0;
        end else begin
            case (state)
                IDLE: if (bus.count != count_q && in_range) begin
                    state      <= WARN;
                    bus.buzzer <= 1'b1;
                    tone       <= '0;
                end
                WARN: if (tone == TW'(BEEP_HALF - 1)) begin
                    state      <= IDLE;
                    bus.buzzer <= 1'b0;
                end else begin
                    tone <= tone + 1'b1;
                end
                ALARM: if (bus.clear) begin
                    state            <= IDLE;
                    bus.buzzer       <= 1'b0;
                    bus.alarm_active <= 1'b0;
                end else if (len == LW'(ALARM_CYC - 1)) begin
                    state      <= HOLD;
                    bus.buzzer <= 1'b0;
                end else begin
                    len <= len + 1'b1;
                    if (tone == TW'(BEEP_HALF - 1)) begin
                        tone       <= '0;
                        bus.buzzer <= ~bus.buzzer;
                    end else begin
                        tone <= tone + 1'b1;
                    end
                end
                HOLD: if (bus.clear) begin
                    state            <= IDLE;
                    bus.alarm_active <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Input history, display, warning level and saturating violation counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buzz_q       <= 1'b0;
            count_q      <= 4'd0;
            bus.seg      <= 7'h3F;
            bus.warn     <= 1'b0;
            bus.viol_cnt <= 8'd0;
        end else begin
            buzz_q   <= bus.buzz;
            count_q  <= bus.count;
            bus.seg  <= digit(bus.count);
            bus.warn <= in_range;
            if (hit && bus.viol_cnt != 8'hFF) bus.viol_cnt <= bus.viol_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_shot_alarm.sv
// tb_shot_alarm: table vectors, directed corner sequences and random stimulus against a cycle-age model
module tb_shot_alarm;
    localparam int AC = 8;
    localparam int BH = 2;
    localparam int WT = 3;

    typedef struct {
        logic [3:0] cnt;
        logic [6:0] seg;
        logic       warn;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    shot_alarm_if bus ();

    shot_alarm #(.ALARM_CYC(AC), .BEEP_HALF(BH), .WARN_THRESH(WT)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    int checks = 0;
    int errors = 0;

    // model: mode 0 quiet, 1 beeping, 2 alarming, 3 holding; start = cycle the mode began
    int         n = 0;
    int         mode = 0;
    int         start = 0;
    int         m_viol = 0;
    logic       pb = 1'b0;
    logic [3:0] pc = 4'd0;
    logic       m_buz = 1'b0;
    logic       m_act = 1'b0;
    logic       m_warn = 1'b0;
    logic [6:0] m_seg = 7'h3F;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, n, act, exp);
        end
    endtask

    task automatic chk_all(input string nm);
        chk({nm, ".buzzer"}, bus.buzzer, m_buz);
        chk({nm, ".seg"}, bus.seg, m_seg);
        chk({nm, ".warn"}, bus.warn, m_warn);
        chk({nm, ".alarm_active"}, bus.alarm_active, m_act);
        chk({nm, ".viol_cnt"}, bus.viol_cnt, m_viol);
    endtask

    task automatic model_reset();
        mode = 0; m_viol = 0; pb = 1'b0; pc = 4'd0;
        m_buz = 1'b0; m_act = 1'b0; m_warn = 1'b0; m_seg = 7'h3F;
    endtask

    task automatic model_edge();
        logic e;
        n++;
        e = bus.buzz && !pb;
        if (e) begin
            mode = 2; start = n;
            if (m_viol < 255) m_viol++;
        end else begin
            case (mode)
                0: if (bus.count != pc && bus.count >= 1 && bus.count <= WT) begin mode = 1; start = n; end
                1: if (n - start == BH) mode = 0;
                2: if (bus.clear) mode = 0; else if (n - start == AC) mode = 3;
                3: if (bus.clear) mode = 0;
                default: mode = 0;
            endcase
        end
        m_buz  = mode == 1 || (mode == 2 && ((n - start) / BH) % 2 == 0);
        m_act  = mode >= 2;
        m_seg  = seg_ref[bus.count];
        m_warn = bus.count >= 1 && bus.count <= WT;
        pb = bus.buzz;
        pc = bus.count;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk_all("model");
    endtask

    task automatic reset_outputs(input string nm);
        chk({nm, ".buzzer"}, bus.buzzer, 0);
        chk({nm, ".seg"}, bus.seg, 'h3F);
        chk({nm, ".warn"}, bus.warn, 0);
        chk({nm, ".alarm_active"}, bus.alarm_active, 0);
        chk({nm, ".viol_cnt"}, bus.viol_cnt, 0);
    endtask

    vec_t tab [16];
    logic [7:0] pat;
    int beeps;

    initial begin
        tab = '{'{4'd0, 7'h3F, 1'b0}, '{4'd1, 7'h06, 1'b1}, '{4'd2, 7'h5B, 1'b1}, '{4'd3, 7'h4F, 1'b1},
                '{4'd4, 7'h66, 1'b0}, '{4'd5, 7'h6D, 1'b0}, '{4'd6, 7'h7D, 1'b0}, '{4'd7, 7'h07, 1'b0},
                '{4'd8, 7'h7F, 1'b0}, '{4'd9, 7'h6F, 1'b0}, '{4'd10, 7'h40, 1'b0}, '{4'd11, 7'h40, 1'b0},
                '{4'd12, 7'h40, 1'b0}, '{4'd13, 7'h40, 1'b0}, '{4'd14, 7'h40, 1'b0}, '{4'd15, 7'h40, 1'b0}};
        bus.count = 4'd0; bus.buzz = 1'b0; bus.clear = 1'b0;
        #12;
        reset_outputs("reset");
        rst = 1'b0;
        model_reset();
        step();

        for (int i = 0; i < 16; i++) begin
            bus.count = tab[i].cnt;
            step();
            chk("seg_tab", bus.seg, tab[i].seg);
            chk("warn_tab", bus.warn, tab[i].warn);
        end
        bus.count = 4'd0;
        repeat (4) step();

        for (int v = 5; v >= 1; v--) begin
            bus.count = 4'(v);
            beeps = 0;
            repeat (10) begin
                step();
                beeps += int'(bus.buzzer);
            end
            chk("beep_len", beeps, v <= WT ? BH : 0);
            chk("warn_level", bus.warn, v <= WT ? 1 : 0);
        end
        chk("warn_viol", bus.viol_cnt, 0);

        bus.count = 4'd0;
        repeat (3) step();
        bus.buzz = 1'b1;
        pat = 8'b11001100;
        for (int k = 7; k >= 0; k--) begin
            step();
            chk("alarm_pattern", bus.buzzer, pat[k]);
            chk("alarm_active", bus.alarm_active, 1);
        end
        step();
        chk("hold_buzzer", bus.buzzer, 0);
        chk("hold_active", bus.alarm_active, 1);
        chk("hold_viol", bus.viol_cnt, 1);
        repeat (3) step();

        bus.clear = 1'b1;
        step();
        chk("hold_clear", bus.alarm_active, 0);
        bus.clear = 1'b0; bus.buzz = 1'b0;
        step();
        bus.buzz = 1'b1;
        repeat (3) step();
        bus.clear = 1'b1;
        step();
        chk("alarm_clear_buzzer", bus.buzzer, 0);
        chk("alarm_clear_active", bus.alarm_active, 0);
        bus.clear = 1'b0;
        repeat (2) step();

        bus.buzz = 1'b0;
        step();
        bus.buzz = 1'b1; bus.clear = 1'b1;
        step();
        chk("edge_clear_active", bus.alarm_active, 1);
        chk("edge_clear_buzzer", bus.buzzer, 1);
        chk("edge_clear_viol", bus.viol_cnt, 3);
        bus.clear = 1'b0;
        step();

        bus.buzz = 1'b0;
        step();
        bus.buzz = 1'b1;
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        model_reset();
        reset_outputs("async_reset");
        @(posedge clk);
        #1;
        reset_outputs("reset_held");
        rst = 1'b0;
        step();
        chk("post_reset_edge_viol", bus.viol_cnt, 1);
        chk("post_reset_edge_active", bus.alarm_active, 1);

        repeat (3000) begin
            if ($urandom_range(7) == 0) bus.buzz = ~bus.buzz;
            bus.clear = $urandom_range(9) == 0;
            if ($urandom_range(5) == 0) bus.count = 4'($urandom_range(15));
            step();
        end

        bus.clear = 1'b0;
        repeat (300) begin
            bus.buzz = 1'b1; step();
            bus.buzz = 1'b0; step();
        end
        chk("viol_saturate", bus.viol_cnt, 255);
        bus.buzz = 1'b1; step();
        bus.buzz = 1'b0; step();
        chk("viol_stays", bus.viol_cnt, 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
